// File: rtl/apb_lite_master24_if.sv
// Bundles the command, response and APB bus signals of apb_lite_master24.
// APB_LITE_MASTER_PREADY_EN adds pready24/pslverr24 to the bundle.
interface apb_lite_master24_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              cmd_valid24;
    logic              cmd_ready24;
    logic              cmd_write24;
    logic [ADDR_W-1:0] cmd_addr24;
    logic [DATA_W-1:0] cmd_wdata24;
    logic              rsp_valid24;
    logic              rsp_ready24;
    logic [DATA_W-1:0] rsp_rdata24;
    logic              rsp_err24;
    logic              psel24;
    logic              penable24;
    logic              pwrite24;
    logic [ADDR_W-1:0] paddr24;
    logic [DATA_W-1:0] pwdata24;
    logic [DATA_W-1:0] prdata24;
`ifdef APB_LITE_MASTER_PREADY_EN
    logic              pready24;
    logic              pslverr24;

    modport master (
        input  cmd_valid24, cmd_write24, cmd_addr24, cmd_wdata24, rsp_ready24,
               prdata24, pready24, pslverr24,
        output cmd_ready24, rsp_valid24, rsp_rdata24, rsp_err24,
               psel24, penable24, pwrite24, paddr24, pwdata24
    );

    modport slave (
        output cmd_valid24, cmd_write24, cmd_addr24, cmd_wdata24, rsp_ready24,
               prdata24, pready24, pslverr24,
        input  cmd_ready24, rsp_valid24, rsp_rdata24, rsp_err24,
               psel24, penable24, pwrite24, paddr24, pwdata24
    );
`else
    modport master (
        input  cmd_valid24, cmd_write24, cmd_addr24, cmd_wdata24, rsp_ready24,
               prdata24,
        output cmd_ready24, rsp_valid24, rsp_rdata24, rsp_err24,
               psel24, penable24, pwrite24, paddr24, pwdata24
    );

    modport slave (
        output cmd_valid24, cmd_write24, cmd_addr24, cmd_wdata24, rsp_ready24,
               prdata24,
        input  cmd_ready24, rsp_valid24, rsp_rdata24, rsp_err24,
               psel24, penable24, pwrite24, paddr24, pwdata24
    );
`endif
endinterface

// File: rtl/apb_lite_master24.sv
// APB initiator: one valid/ready command becomes one APB transfer and one response.
// APB_LITE_MASTER_PREADY_EN enables pready24 wait states, pslverr24 and a TIMEOUT abort.
module apb_lite_master24 #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
`ifdef APB_LITE_MASTER_PREADY_EN
    ,parameter int TIMEOUT = 16
`endif
) (
    input  logic                pclk24,
    input  logic                p_reset24,
    apb_lite_master24_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              w_complete;
    logic              r_cmdReady;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rspValid;
    logic [DATA_W-1:0] r_rspRdata;

`ifdef APB_LITE_MASTER_PREADY_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic             w_abort;
    logic             r_rspErr;
    logic [CNT_W-1:0] r_waitCnt;
`endif

    always_comb begin
        w_nextState = r_state;
        w_complete  = 1'b0;
`ifdef APB_LITE_MASTER_PREADY_EN
        w_abort     = 1'b0;
`endif
        case (r_state)
            IDLE:   if (bus.cmd_valid24) w_nextState = SETUP;
            SETUP:  w_nextState = ACCESS;
            ACCESS: begin
`ifdef APB_LITE_MASTER_PREADY_EN
                // The count holds completed wait cycles, so hitting TIMEOUT-1 here ends the TIMEOUT-th one.
                if (bus.pready24) begin
                    w_complete  = 1'b1;
                    w_nextState = RESP;
                end else if (r_waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_nextState = RESP;
                end
`else
                w_complete  = 1'b1;
                w_nextState = RESP;
`endif
            end
            RESP:   if (bus.rsp_ready24) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Bus strobes are decoded from the next state so every output comes straight from a flop.
    always_ff @(posedge pclk24) begin
        if (p_reset24) begin
            r_state    <= IDLE;
            r_cmdReady <= 1'b1;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rspValid <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            r_state    <= w_nextState;
            r_cmdReady <= (w_nextState == IDLE);
            r_psel     <= (w_nextState == SETUP) || (w_nextState == ACCESS);
            r_penable  <= (w_nextState == ACCESS);
            r_rspValid <= (w_nextState == RESP);
            if (r_state == IDLE && bus.cmd_valid24) begin
                r_pwrite <= bus.cmd_write24;
                r_paddr  <= bus.cmd_addr24;
                r_pwdata <= bus.cmd_wdata24;
            end
            if (w_complete) begin
                r_rspRdata <= r_pwrite ? '0 : bus.prdata24;
            end
`ifdef APB_LITE_MASTER_PREADY_EN
            if (w_abort) begin
                r_rspRdata <= '0;
            end
`endif
        end
    end

`ifdef APB_LITE_MASTER_PREADY_EN
    always_ff @(posedge pclk24) begin
        if (p_reset24) begin
            r_rspErr  <= 1'b0;
            r_waitCnt <= '0;
        end else begin
            if (r_state != ACCESS) begin
                r_waitCnt <= '0;
            end else if (!bus.pready24) begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
            if (w_complete) begin
                r_rspErr <= bus.pslverr24;
            end else if (w_abort) begin
                r_rspErr <= 1'b1;
            end
        end
    end

    assign bus.rsp_err24 = r_rspErr;
`else
    assign bus.rsp_err24 = 1'b0;
`endif

    assign bus.cmd_ready24 = r_cmdReady;
    assign bus.psel24      = r_psel;
    assign bus.penable24   = r_penable;
    assign bus.pwrite24    = r_pwrite;
    assign bus.paddr24     = r_paddr;
    assign bus.pwdata24    = r_pwdata;
    assign bus.rsp_valid24 = r_rspValid;
    assign bus.rsp_rdata24 = r_rspRdata;

endmodule

// File: tb/tb_apb_lite_master24.sv
// Directed self-checking bench for apb_lite_master24; define APB_LITE_MASTER_PREADY_EN
// to also exercise wait states, slave error and the timeout abort.
module tb_apb_lite_master24;

    logic pclk24;
    logic p_reset24;
    int   passCount;
    int   checkCount;

    apb_lite_master24_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    apb_lite_master24 #(.ADDR_W(6), .DATA_W(32)) dut (
        .pclk24    (pclk24),
        .p_reset24 (p_reset24),
        .bus       (bus)
    );

    initial pclk24 = 1'b0;
    always #5 pclk24 = ~pclk24;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge pclk24);
        #1;
    endtask

    task automatic test_reset;
        p_reset24 = 1'b1;
        tick;
        tick;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.pwrite24, bus.rsp_valid24, bus.rsp_err24, bus.cmd_ready24} !== 6'b000001)
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {bus.psel24, bus.penable24, bus.pwrite24, bus.rsp_valid24, bus.rsp_err24, bus.cmd_ready24}, 6'b000001);
        else passCount++;
        checkCount++;
        if ({bus.paddr24, bus.pwdata24, bus.rsp_rdata24} !== 70'd0)
            $display("[TB] FAIL reset_data: got %h expected 0", {bus.paddr24, bus.pwdata24, bus.rsp_rdata24});
        else passCount++;
        p_reset24 = 1'b0;
        tick;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24} !== 4'b0010)
            $display("[TB] FAIL idle_after_reset: got %b expected %b",
                     {bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24}, 4'b0010);
        else passCount++;
    endtask

    task automatic test_write;
        bus.prdata24    = 32'hDEADBEEF;
        bus.cmd_valid24 = 1'b1;
        bus.cmd_write24 = 1'b1;
        bus.cmd_addr24  = 6'h04;
        bus.cmd_wdata24 = 32'h0000A5A5;
        tick;
        bus.cmd_valid24 = 1'b0;
        bus.cmd_addr24  = 6'h3F;
        bus.cmd_wdata24 = 32'hFFFFFFFF;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24} !== 4'b1000)
            $display("[TB] FAIL write_setup_ctrl: got %b expected %b",
                     {bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24}, 4'b1000);
        else passCount++;
        checkCount++;
        if ({bus.pwrite24, bus.paddr24, bus.pwdata24} !== {1'b1, 6'h04, 32'h0000A5A5})
            $display("[TB] FAIL write_setup_bus: got %h expected %h",
                     {bus.pwrite24, bus.paddr24, bus.pwdata24}, {1'b1, 6'h04, 32'h0000A5A5});
        else passCount++;
        tick;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.paddr24, bus.pwdata24} !== {2'b11, 6'h04, 32'h0000A5A5})
            $display("[TB] FAIL write_access: got %h expected %h",
                     {bus.psel24, bus.penable24, bus.paddr24, bus.pwdata24}, {2'b11, 6'h04, 32'h0000A5A5});
        else passCount++;
        tick;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24, bus.rsp_err24, bus.rsp_rdata24} !== {5'b00010, 32'h0})
            $display("[TB] FAIL write_resp: got %h expected %h",
                     {bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24, bus.rsp_err24, bus.rsp_rdata24}, {5'b00010, 32'h0});
        else passCount++;
        tick;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24} !== 4'b0010)
            $display("[TB] FAIL write_back_idle: got %b expected %b",
                     {bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24}, 4'b0010);
        else passCount++;
    endtask

    task automatic test_read;
        bus.prdata24    = 32'h00001234;
        bus.cmd_valid24 = 1'b1;
        bus.cmd_write24 = 1'b0;
        bus.cmd_addr24  = 6'h08;
        tick;
        bus.cmd_valid24 = 1'b0;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.pwrite24, bus.paddr24} !== {3'b100, 6'h08})
            $display("[TB] FAIL read_setup: got %h expected %h",
                     {bus.psel24, bus.penable24, bus.pwrite24, bus.paddr24}, {3'b100, 6'h08});
        else passCount++;
        tick;
        tick;
        bus.prdata24 = 32'hFFFF0000;
        checkCount++;
        if ({bus.rsp_valid24, bus.rsp_err24, bus.rsp_rdata24} !== {2'b10, 32'h00001234})
            $display("[TB] FAIL read_resp: got %h expected %h",
                     {bus.rsp_valid24, bus.rsp_err24, bus.rsp_rdata24}, {2'b10, 32'h00001234});
        else passCount++;
        tick;
    endtask

    task automatic test_back_to_back;
        bus.prdata24    = 32'h0000CAFE;
        bus.cmd_valid24 = 1'b1;
        bus.cmd_write24 = 1'b0;
        bus.cmd_addr24  = 6'h11;
        tick;
        bus.cmd_write24 = 1'b1;
        bus.cmd_addr24  = 6'h22;
        bus.cmd_wdata24 = 32'h87654321;
        tick;
        tick;
        checkCount++;
        if ({bus.rsp_valid24, bus.rsp_rdata24} !== {1'b1, 32'h0000CAFE})
            $display("[TB] FAIL b2b_first_resp: got %h expected %h",
                     {bus.rsp_valid24, bus.rsp_rdata24}, {1'b1, 32'h0000CAFE});
        else passCount++;
        tick;
        checkCount++;
        if ({bus.psel24, bus.cmd_ready24, bus.rsp_valid24, bus.paddr24} !== {3'b010, 6'h11})
            $display("[TB] FAIL b2b_idle_gap: got %h expected %h",
                     {bus.psel24, bus.cmd_ready24, bus.rsp_valid24, bus.paddr24}, {3'b010, 6'h11});
        else passCount++;
        tick;
        bus.cmd_valid24 = 1'b0;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.pwrite24, bus.paddr24, bus.pwdata24} !== {3'b101, 6'h22, 32'h87654321})
            $display("[TB] FAIL b2b_second_setup: got %h expected %h",
                     {bus.psel24, bus.penable24, bus.pwrite24, bus.paddr24, bus.pwdata24}, {3'b101, 6'h22, 32'h87654321});
        else passCount++;
        tick;
        tick;
        checkCount++;
        if ({bus.rsp_valid24, bus.rsp_rdata24} !== {1'b1, 32'h0})
            $display("[TB] FAIL b2b_second_resp: got %h expected %h",
                     {bus.rsp_valid24, bus.rsp_rdata24}, {1'b1, 32'h0});
        else passCount++;
        tick;
    endtask

    task automatic test_backpressure;
        int stableErrors;
        stableErrors    = 0;
        bus.prdata24    = 32'h000055AA;
        bus.cmd_valid24 = 1'b1;
        bus.cmd_write24 = 1'b0;
        bus.cmd_addr24  = 6'h0C;
        bus.rsp_ready24 = 1'b0;
        tick;
        bus.cmd_valid24 = 1'b0;
        tick;
        tick;
        bus.cmd_valid24 = 1'b1;
        bus.cmd_write24 = 1'b1;
        bus.cmd_addr24  = 6'h10;
        bus.cmd_wdata24 = 32'h13572468;
        for (int i = 0; i < 5; i++) begin
            bus.prdata24 = 32'h11110000 + i;
            if ({bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24, bus.rsp_rdata24, bus.paddr24} !==
                {4'b0001, 32'h000055AA, 6'h0C})
                stableErrors++;
            tick;
        end
        checkCount++;
        if (stableErrors !== 0)
            $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", stableErrors);
        else passCount++;
        bus.rsp_ready24 = 1'b1;
        tick;
        checkCount++;
        if ({bus.psel24, bus.cmd_ready24, bus.rsp_valid24, bus.paddr24} !== {3'b010, 6'h0C})
            $display("[TB] FAIL bp_after_handshake: got %h expected %h",
                     {bus.psel24, bus.cmd_ready24, bus.rsp_valid24, bus.paddr24}, {3'b010, 6'h0C});
        else passCount++;
        tick;
        bus.cmd_valid24 = 1'b0;
        checkCount++;
        if ({bus.psel24, bus.pwrite24, bus.paddr24, bus.pwdata24} !== {2'b11, 6'h10, 32'h13572468})
            $display("[TB] FAIL bp_second_accepted: got %h expected %h",
                     {bus.psel24, bus.pwrite24, bus.paddr24, bus.pwdata24}, {2'b11, 6'h10, 32'h13572468});
        else passCount++;
        tick;
        tick;
        tick;
    endtask

    task automatic test_reset_mid;
        int sawRsp;
        sawRsp          = 0;
        bus.cmd_valid24 = 1'b1;
        bus.cmd_write24 = 1'b1;
        bus.cmd_addr24  = 6'h2A;
        bus.cmd_wdata24 = 32'h0BADF00D;
        tick;
        bus.cmd_valid24 = 1'b0;
        tick;
        p_reset24 = 1'b1;
        tick;
        p_reset24 = 1'b0;
        checkCount++;
        if ({bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24, bus.paddr24} !== {4'b0010, 6'h00})
            $display("[TB] FAIL reset_mid_state: got %h expected %h",
                     {bus.psel24, bus.penable24, bus.cmd_ready24, bus.rsp_valid24, bus.paddr24}, {4'b0010, 6'h00});
        else passCount++;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid24 !== 1'b0) sawRsp++;
            tick;
        end
        checkCount++;
        if (sawRsp !== 0)
            $display("[TB] FAIL reset_mid_no_rsp: got %0d response cycles expected 0", sawRsp);
        else passCount++;
    endtask

`ifdef APB_LITE_MASTER_PREADY_EN
    task automatic test_wait_states;
        int accCycles;
        int instab;
        accCycles       = 0;
        instab          = 0;
        bus.pready24    = 1'b0;
        bus.pslverr24   = 1'b1;
        bus.prdata24    = 32'h00000077;
        bus.cmd_valid24 = 1'b1;
        bus.cmd_write24 = 1'b0;
        bus.cmd_addr24  = 6'h05;
        tick;
        bus.cmd_valid24 = 1'b0;
        for (int i = 0; i < 40 && bus.rsp_valid24 !== 1'b1; i++) begin
            tick;
            if (bus.psel24 === 1'b1 && bus.penable24 === 1'b1) begin
                accCycles++;
                if (bus.paddr24 !== 6'h05 || bus.pwrite24 !== 1'b0) instab++;
            end
            bus.pready24 = (accCycles == 4);
        end
        checkCount++;
        if (accCycles !== 4 || instab !== 0)
            $display("[TB] FAIL wait_access_len: got %0d cycles (%0d unstable) expected 4 (0)", accCycles, instab);
        else passCount++;
        checkCount++;
        if ({bus.rsp_valid24, bus.rsp_err24, bus.rsp_rdata24} !== {2'b11, 32'h00000077})
            $display("[TB] FAIL wait_slverr_resp: got %h expected %h",
                     {bus.rsp_valid24, bus.rsp_err24, bus.rsp_rdata24}, {2'b11, 32'h00000077});
        else passCount++;
        bus.pslverr24 = 1'b0;
        bus.pready24  = 1'b1;
        tick;
    endtask

    task automatic test_timeout;
        int accCycles;
        accCycles       = 0;
        bus.pready24    = 1'b0;
        bus.prdata24    = 32'h99999999;
        bus.cmd_valid24 = 1'b1;
        bus.cmd_write24 = 1'b0;
        bus.cmd_addr24  = 6'h06;
        tick;
        bus.cmd_valid24 = 1'b0;
        for (int i = 0; i < 60 && bus.rsp_valid24 !== 1'b1; i++) begin
            tick;
            if (bus.psel24 === 1'b1 && bus.penable24 === 1'b1) accCycles++;
        end
        checkCount++;
        if (accCycles !== 16)
            $display("[TB] FAIL timeout_len: got %0d cycles expected 16", accCycles);
        else passCount++;
        checkCount++;
        if ({bus.rsp_valid24, bus.rsp_err24, bus.rsp_rdata24} !== {2'b11, 32'h0})
            $display("[TB] FAIL timeout_resp: got %h expected %h",
                     {bus.rsp_valid24, bus.rsp_err24, bus.rsp_rdata24}, {2'b11, 32'h0});
        else passCount++;
        bus.pready24 = 1'b1;
        tick;
    endtask
`endif

    initial begin
        passCount       = 0;
        checkCount      = 0;
        p_reset24       = 1'b1;
        bus.cmd_valid24 = 1'b0;
        bus.cmd_write24 = 1'b0;
        bus.cmd_addr24  = '0;
        bus.cmd_wdata24 = '0;
        bus.rsp_ready24 = 1'b1;
        bus.prdata24    = '0;
`ifdef APB_LITE_MASTER_PREADY_EN
        bus.pready24    = 1'b1;
        bus.pslverr24   = 1'b0;
`endif
        $display("[TB] starting apb_lite_master24 bench");
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
`ifdef APB_LITE_MASTER_PREADY_EN
        test_wait_states;
        test_timeout;
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/apb_lite_master24.md
Name: apb_lite_master24

Overview:
- APB (AMBA Rev 2) initiator that turns a simple valid/ready command stream into single APB transfers. It drives psel/penable/pwrite/paddr/pwdata toward APB peripherals such as the gpio lite block.
- It captures prdata and returns one response per command on a valid/ready response channel.
- Only one transfer is outstanding at a time. Sits between an on-chip controller (DMA, test sequencer, bridge) and the peripheral APB bus.

Parameters:
- ADDR_W, 6, width of paddr24/cmd_addr24.
- DATA_W, 32, width of pwdata24/prdata24/cmd_wdata24/rsp_rdata24.
- TIMEOUT, 16, max ACCESS-phase cycles with pready24 low before abort (used only with the optional feature; must be ≥2).

Ports:
- pclk24  in  1  clock, all logic on rising edge
- p_reset24  in  1  synchronous, active-high reset
- cmd_valid24  in  1  command present
- cmd_ready24  out  1  command accepted this cycle when high with cmd_valid24
- cmd_write24  in  1  1=write, 0=read
- cmd_addr24  in  ADDR_W  target address
- cmd_wdata24  in  DATA_W  write data
- rsp_valid24  out  1  response present
- rsp_ready24  in  1  response consumed
- rsp_rdata24  out  DATA_W  read data; 0 for writes
- rsp_err24  out  1  transfer error (always 0 without the optional feature)
- psel24  out  1  APB select
- penable24  out  1  APB enable
- pwrite24  out  1  APB write
- paddr24  out  ADDR_W  APB address
- pwdata24  out  DATA_W  APB write data
- prdata24  in  DATA_W  APB read data

Behaviour:
- Decided: one clock, pclk24; reset p_reset24 is synchronous and active-high.
- All outputs are registered.
- Reset values: psel24, penable24, pwrite24, paddr24, pwdata24, rsp_valid24, rsp_rdata24, rsp_err24 = 0; cmd_ready24 = 1.
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset enters IDLE.
- IDLE:
  - cmd_ready24 = 1.
  - On cmd_valid24 & cmd_ready24 at edge T: register cmd_write24/addr/wdata into pwrite24/paddr24/pwdata24, go to SETUP.
- SETUP (cycle T+1):
  - psel24 = 1, penable24 = 0, cmd_ready24 = 0.
  - Unconditionally go to ACCESS.
- ACCESS (cycle T+2):
  - psel24 = 1, penable24 = 1.
  - Without the feature, the transfer completes at the end of this cycle.
  - On a read, prdata24 is sampled at that edge into rsp_rdata24; on a write, rsp_rdata24 = 0.
  - Go to RESP.
- RESP (cycle T+3 onward):
  - psel24 = 0, penable24 = 0, rsp_valid24 = 1.
  - rsp_rdata24 and rsp_err24 stay stable until rsp_valid24 & rsp_ready24.
  - On that handshake go to IDLE. cmd_ready24 returns to 1 in the next cycle.
- paddr24, pwdata24 and pwrite24 are stable from SETUP through the end of ACCESS. They hold their last value in IDLE/RESP; they are not cleared.
- Throughput: minimum 4 cycles per command with rsp_ready24 tied high.
- Commands presented while cmd_ready24 = 0 are neither consumed nor corrupted. The upstream source holds them until accepted.
- rsp_ready24 asserted while rsp_valid24 = 0 is ignored.
- p_reset24 asserted in any state: next edge enters IDLE with reset values on all outputs. An in-flight transfer is dropped with no response. A pending, not yet acknowledged response is discarded.
- psel24 never rises with penable24 already high. penable24 is high only in the second and later cycles of a select period.

Optional Feature:
- Macro: APB_LITE_MASTER_PREADY_EN.
- When defined:
  - Adds inputs pready24 (1) and pslverr24 (1).
  - ACCESS repeats while pready24 = 0, keeping psel24/penable24/paddr24/pwdata24/pwrite24 stable.
  - Completion happens at the edge where pready24 = 1: prdata24 is captured on reads and rsp_err24 takes pslverr24.
  - A wait counter, cleared on entry to ACCESS, counts cycles with pready24 = 0. If it reaches TIMEOUT, the FSM aborts to RESP with rsp_err24 = 1 and rsp_rdata24 = 0.
- When undefined: no extra ports; every ACCESS lasts exactly 1 cycle; rsp_err24 is tied 0.

Test Plan:
- Reset then idle: hold p_reset24 for 2 cycles → all APB outputs and rsp_valid24 are 0, cmd_ready24 = 1.
- Write: cmd write addr 0x04, data 0x0000A5A5 → SETUP at T+1 (psel24=1, penable24=0, paddr24=0x04, pwdata24=0xA5A5), ACCESS at T+2, rsp_valid24 at T+3 with rsp_rdata24=0, rsp_err24=0.
- Read: cmd read addr 0x08, bus model drives prdata24=0x00001234 during ACCESS → rsp_rdata24=0x00001234 at T+3.
- Backpressure: rsp_ready24 low for 5 cycles → rsp held stable, cmd_ready24=0, psel24=0; a second cmd_valid24 is not accepted until the cycle after the response handshake.
- Reset mid-transfer: assert p_reset24 during ACCESS → next cycle psel24=penable24=0, no rsp_valid24 ever produced for that command.
- With APB_LITE_MASTER_PREADY_EN, TIMEOUT=16:
  - pready24 low for 3 cycles then high with pslverr24=1 → ACCESS lasts 4 cycles, rsp_err24=1.
  - pready24 held low → abort after 16 wait cycles with rsp_err24=1.
